// File: rtl/gamma_cycle_sched_pkg.sv
// Shared types and constants for the gamma-cycle sequencer.
// TEMPORAL_FALLING_EN selects falling-edge encoding (idle high, active low).
package gamma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int tc_width(input int gamma);
        return $clog2(gamma);
    endfunction

`ifdef TEMPORAL_FALLING_EN
    localparam logic EDGE_INACTIVE = 1'b1;
`else
    localparam logic EDGE_INACTIVE = 1'b0;
`endif

endpackage

// File: rtl/gamma_cycle_sched_tc_edge_encoder.sv
// Per-lane temporal encoder: the lane goes active once the gamma-cycle time
// reaches its operand time and stays active for the rest of the run.
module tc_edge_encoder
    import gamma_pkg::*;
#(
    parameter int TW = 4
) (
    input  logic [TW-1:0] t,
    input  logic [TW-1:0] time_i,
    input  logic          inf_i,
    input  logic          run,
    output logic          edge_lvl
);

    assign edge_lvl = (run && !inf_i && (t >= time_i)) ? ~EDGE_INACTIVE : EDGE_INACTIVE;

endmodule

// File: rtl/gamma_cycle_sched.sv
// Gamma-cycle sequencer for race-logic compare datapaths: clear, drive edges,
// capture first result edge. TEMPORAL_FALLING_EN selects falling encoding.
module gamma_cycle_sched
    import gamma_pkg::*;
#(
    parameter  int GAMMA_CYCLE_WIDTH = 16,
    parameter  int NUM_IN            = 2,
    parameter  int CLEAR_CYCLES      = 2,
    localparam int TW                = tc_width(GAMMA_CYCLE_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_IN*TW-1:0] in_time,
    input  logic [NUM_IN-1:0]    in_inf,
    output logic                 tc_rst,
    output logic [NUM_IN-1:0]    edge_out,
    input  logic                 res_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TW-1:0]        res_time,
    output logic                 res_inf
);

    // Counter is shared by CLEAR and RUN, so size it for the longer of the two.
    localparam int CW = (CLEAR_CYCLES > GAMMA_CYCLE_WIDTH) ? $clog2(CLEAR_CYCLES) : TW;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_IN*TW-1:0]  time_q, time_d;
    logic [NUM_IN-1:0]     inf_q, inf_d;
    logic                  cap_q, cap_d;
    logic                  tc_rst_q, tc_rst_d;
    logic [NUM_IN-1:0]     edge_q, edge_d;
    logic                  out_valid_q, out_valid_d;
    logic [TW-1:0]         res_time_q, res_time_d;
    logic                  res_inf_q, res_inf_d;
    logic [NUM_IN-1:0]     enc_lvl;
    logic                  res_active;

    assign res_active = res_in ^ EDGE_INACTIVE;

    // Encoders look at next-state time so the registered edges line up with t.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        tc_edge_encoder #(.TW(TW)) u_enc (
            .t       (cnt_d[TW-1:0]),
            .time_i  (time_q[i*TW +: TW]),
            .inf_i   (inf_q[i]),
            .run     (state_d == RUN),
            .edge_lvl(enc_lvl[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        time_d      = time_q;
        inf_d       = inf_q;
        cap_d       = cap_q;
        out_valid_d = out_valid_q;
        res_time_d  = res_time_q;
        res_inf_d   = res_inf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    time_d     = in_time;
                    inf_d      = in_inf;
                    cap_d      = 1'b0;
                    cnt_d      = '0;
                    res_time_d = '0;
                    res_inf_d  = 1'b0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt_q == CW'(CLEAR_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (res_active && !cap_q) begin
                    res_time_d = cnt_q[TW-1:0];
                    cap_d      = 1'b1;
                end
                if (cnt_q == CW'(GAMMA_CYCLE_WIDTH - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    res_inf_d   = !(cap_q || res_active);
                    if (!(cap_q || res_active)) res_time_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tc_rst_d = (state_d == IDLE) || (state_d == CLEAR);
        edge_d   = (state_d == DONE) ? edge_q : enc_lvl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            time_q      <= '0;
            inf_q       <= '0;
            cap_q       <= 1'b0;
            tc_rst_q    <= 1'b1;
            edge_q      <= {NUM_IN{EDGE_INACTIVE}};
            out_valid_q <= 1'b0;
            res_time_q  <= '0;
            res_inf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            time_q      <= time_d;
            inf_q       <= inf_d;
            cap_q       <= cap_d;
            tc_rst_q    <= tc_rst_d;
            edge_q      <= edge_d;
            out_valid_q <= out_valid_d;
            res_time_q  <= res_time_d;
            res_inf_q   <= res_inf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign tc_rst    = tc_rst_q;
    assign edge_out  = edge_q;
    assign out_valid = out_valid_q;
    assign res_time  = res_time_q;
    assign res_inf   = res_inf_q;

endmodule

// File: tb/tb_gamma_cycle_sched.sv
// Scoreboard bench for gamma_cycle_sched: directed operand sets, results
// checked by an independent monitor when out_valid rises.
module tb_gamma_cycle_sched;

    localparam int G  = 16;
    localparam int N  = 2;
    localparam int C  = 2;
    localparam int TW = 4;
`ifdef TEMPORAL_FALLING_EN
    localparam logic INACT = 1'b1;
`else
    localparam logic INACT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*TW-1:0] in_time;
    logic [N-1:0]    in_inf;
    logic            tc_rst;
    logic [N-1:0]    edge_out;
    logic            res_in;
    logic            out_valid;
    logic            out_ready;
    logic [TW-1:0]   res_time;
    logic            res_inf;
    logic            gate_min;

    // gate_min picks the "earliest edge" gate, otherwise the "latest edge" gate.
    assign res_in = (gate_min ^ INACT) ? (edge_out[0] | edge_out[1])
                                       : (edge_out[0] & edge_out[1]);

    gamma_cycle_sched #(
        .GAMMA_CYCLE_WIDTH(G),
        .NUM_IN           (N),
        .CLEAR_CYCLES     (C)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_time  (in_time),
        .in_inf   (in_inf),
        .tc_rst   (tc_rst),
        .edge_out (edge_out),
        .res_in   (res_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res_time (res_time),
        .res_inf  (res_inf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [TW-1:0] t;
        logic          inf;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] exp_edge(input int t, input logic [TW-1:0] t0,
                                              input logic [TW-1:0] t1, input logic [N-1:0] inf);
        logic [N-1:0] e;
        e[0] = (!inf[0] && t >= int'(t0)) ? ~INACT : INACT;
        e[1] = (!inf[1] && t >= int'(t1)) ? ~INACT : INACT;
        return e;
    endfunction

    // Monitor: pops one expectation per out_valid rise.
    initial begin
        logic ov_prev;
        exp_t e;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && ov_prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got res_time=%0d res_inf=%0b with nothing pending",
                             res_time, res_inf);
                end else begin
                    e = sb.pop_front();
                    chk("res_time", res_time, e.t);
                    chk("res_inf", res_inf, e.inf);
                    // accept edge counted as the first of the latency edges
                    chk("latency", cyc - e.acc + 1, C + G + 1);
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic run_op(input logic [TW-1:0] t0, input logic [TW-1:0] t1, input logic [N-1:0] inf,
                          input logic gmin, input logic [TW-1:0] et, input logic einf,
                          input int hold, input int abort_t);
        int n;
        int acc;
        logic [N-1:0] last;
        gate_min = gmin;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1) begin
            if (n++ > 50) begin
                chk("ready_timeout", in_ready, 1);
                return;
            end
            @(negedge clk);
        end
        in_time  = {t1, t0};
        in_inf   = inf;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc = cyc;
        if (abort_t < 0) sb.push_back(exp_t'{t: et, inf: einf, acc: acc});
        repeat (C) begin
            @(negedge clk);
            chk("clear_tc_rst", tc_rst, 1);
            chk("clear_edge", edge_out, {N{INACT}});
            chk("clear_in_ready", in_ready, 0);
        end
        for (int t = 0; t < G; t++) begin
            @(negedge clk);
            chk("run_edge", edge_out, exp_edge(t, t0, t1, inf));
            if (t == 0) chk("run_tc_rst", tc_rst, 0);
            if (t == abort_t) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_tc_rst", tc_rst, 1);
                chk("abort_edge", edge_out, {N{INACT}});
                chk("abort_out_valid", out_valid, 0);
                chk("abort_in_ready", in_ready, 1);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        last = exp_edge(G - 1, t0, t1, inf);
        @(negedge clk);
        chk("done_out_valid", out_valid, 1);
        chk("done_tc_rst", tc_rst, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_time  = 8'h00;
            in_inf   = 2'b00;
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_res_time", res_time, et);
            chk("hold_res_inf", res_inf, einf);
            chk("hold_edge", edge_out, last);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_tc_rst", tc_rst, 1);
        chk("idle_edge", edge_out, {N{INACT}});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_time   = '0;
        in_inf    = '0;
        out_ready = 1'b0;
        gate_min  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tc_rst", tc_rst, 1);
        chk("rst_edge", edge_out, {N{INACT}});
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_time", res_time, 0);
        chk("rst_res_inf", res_inf, 0);
        rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midclk_rst_tc_rst", tc_rst, 1);
        chk("midclk_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        //     t0     t1     inf    gmin  exp_t  exp_inf hold abort
        run_op(4'd5,  4'd9,  2'b00, 1'b0, 4'd9,  1'b0,   0,   -1);
        run_op(4'd0,  4'd3,  2'b10, 1'b0, 4'd0,  1'b1,   0,   -1);
        run_op(4'd0,  4'd3,  2'b10, 1'b1, 4'd0,  1'b0,   0,   -1);
        run_op(4'd5,  4'd9,  2'b00, 1'b0, 4'd9,  1'b0,   5,   -1);
        run_op(4'd5,  4'd9,  2'b00, 1'b0, 4'd9,  1'b0,   0,   7);
        run_op(4'd2,  4'd4,  2'b00, 1'b0, 4'd4,  1'b0,   0,   -1);
        run_op(4'd15, 4'd15, 2'b00, 1'b0, 4'd15, 1'b0,   0,   -1);
        run_op(4'd3,  4'd7,  2'b11, 1'b1, 4'd0,  1'b1,   0,   -1);
        run_op(4'd6,  4'd1,  2'b00, 1'b1, 4'd1,  1'b0,   2,   -1);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
